// File: rtl/pattern_capture_pkg.sv
// Shared types for the trigger-qualified capture analyzer:
// FSM state encoding, control bit indices and sticky error bit indices.
package pattern_capture_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_PRETRIG  = 3'd1,
        ST_ARMED    = 3'd2,
        ST_POSTTRIG = 3'd3,
        ST_DONE     = 3'd4
    } FSM_State;

    localparam int CTRL_EDGE  = 0;
    localparam int CTRL_FORCE = 1;

    localparam int ERR_RD_IDLE  = 0;
    localparam int ERR_RD_OVER  = 1;
    localparam int ERR_ARM_ZERO = 2;
    localparam int ERR_ARM_BUSY = 3;

endpackage

// File: rtl/capture_trigger_match.sv
// Trigger qualifier: masked compare, match history, level/edge/force select.
// Ports: clk_i/rst_i, restart_i (clear history), en_i (evaluate tick),
//   ctrl_i {force, edge}, sig_i/mask_i/value_i, trig_o.
module capture_trigger_match
    import pattern_capture_pkg::*;
#(
    parameter int NUM_SIG = 14
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               restart_i,
    input  logic               en_i,
    input  logic [1:0]         ctrl_i,
    input  logic [NUM_SIG-1:0] sig_i,
    input  logic [NUM_SIG-1:0] mask_i,
    input  logic [NUM_SIG-1:0] value_i,
    output logic               trig_o
);

    logic match;
    logic prev_match_q, prev_match_d;
    // An edge needs one earlier ARMED sample; without it a line already
    // matching at arm would look like a fresh rising edge.
    logic hist_q, hist_d;

    assign match = (sig_i & mask_i) == (value_i & mask_i);

    always_comb begin
        prev_match_d = prev_match_q;
        hist_d       = hist_q;
        if (restart_i) begin
            prev_match_d = 1'b0;
            hist_d       = 1'b0;
        end else if (en_i) begin
            prev_match_d = match;
            hist_d       = 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            prev_match_q <= 1'b0;
            hist_q       <= 1'b0;
        end else begin
            prev_match_q <= prev_match_d;
            hist_q       <= hist_d;
        end
    end

    assign trig_o = ctrl_i[CTRL_FORCE]
                  | (ctrl_i[CTRL_EDGE] ? (match & ~prev_match_q & hist_q)
                                       : match);

endmodule

// File: rtl/pattern_capture_analyzer.sv
// Trigger-qualified logic analyzer: circular capture of input_signals,
// stop after post-trigger count, oldest-first read-out on rdStrobe edges.
// Ports: axi_clk/axi_reset, arm/clear, capture config (n_samples, pre_trigger,
//   prescale, trig_mask/value, control), input_signals, read_channel_rdStrobe;
//   outputs read_channel, sample_count, trig_index, status, dbg_error.
module pattern_capture_analyzer
    import pattern_capture_pkg::*;
#(
    parameter int NUM_SIG    = 14,
    parameter int NUM_SAMP   = 128,
    parameter int PRESCALE_W = 16
) (
    input  logic                  axi_clk,
    input  logic                  axi_reset,
    input  logic                  arm,
    input  logic                  clear,
    input  logic [31:0]           n_samples,
    input  logic [31:0]           pre_trigger,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic [NUM_SIG-1:0]    trig_mask,
    input  logic [NUM_SIG-1:0]    trig_value,
    input  logic [7:0]            control,
    input  logic [NUM_SIG-1:0]    input_signals,
    input  logic                  read_channel_rdStrobe,
    output logic [NUM_SIG-1:0]    read_channel,
    output logic [31:0]           sample_count,
    output logic [31:0]           trig_index,
    output logic [2:0]            status,
    output logic [31:0]           dbg_error
);

    localparam int CW = $clog2(NUM_SAMP + 1);
    localparam int AW = $clog2(NUM_SAMP);

    FSM_State            state_q, state_d;
    logic [PRESCALE_W-1:0] cnt_q, cnt_d;
    logic [CW-1:0]       n_eff_q, n_eff_d, pre_eff_q, pre_eff_d;
    logic [NUM_SIG-1:0]  mask_q, mask_d, value_q, value_d;
    logic [CW-1:0]       wr_ptr_q, wr_ptr_d, trig_q, trig_d;
    logic [CW-1:0]       post_q, post_d, start_q, start_d;
    logic [CW-1:0]       rd_ofs_q, rd_ofs_d;
    logic [31:0]         cnt_smp_q, cnt_smp_d;
    logic [NUM_SIG-1:0]  rd_q, rd_d;
    logic [3:0]          err_q, err_d;
    logic                strb_q;

    logic [NUM_SIG-1:0]  mem_q [NUM_SAMP];

    logic          tick, busy, arm_go, strb_rise, trig, mem_we, to_done;
    logic [CW-1:0] n_arm, pre_arm, post_val, rem;
    logic [AW-1:0] rd_idx;
    logic          unused;

    assign unused    = ^control[7:2];
    assign tick      = cnt_q == prescale;
    assign busy      = state_q inside {ST_PRETRIG, ST_ARMED, ST_POSTTRIG};
    assign strb_rise = read_channel_rdStrobe & ~strb_q;
    assign arm_go    = arm & ~clear & ~busy & (n_samples != 32'd0);

    // n_arm >= 1 whenever arm_go, so n_arm-1 never underflows in use.
    assign n_arm   = (n_samples > 32'(NUM_SAMP)) ? CW'(NUM_SAMP)
                                                 : n_samples[CW-1:0];
    assign pre_arm = (pre_trigger >= 32'(n_arm)) ? n_arm - CW'(1)
                                                 : pre_trigger[CW-1:0];
    assign post_val = n_eff_q - pre_eff_q - CW'(1);

    capture_trigger_match #(.NUM_SIG(NUM_SIG)) u_trig (
        .clk_i     (axi_clk),
        .rst_i     (axi_reset),
        .restart_i (clear | arm_go),
        .en_i      ((state_q == ST_ARMED) & tick & ~clear),
        .ctrl_i    (control[1:0]),
        .sig_i     (input_signals),
        .mask_i    (mask_q),
        .value_i   (value_q),
        .trig_o    (trig)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = tick ? '0 : cnt_q + PRESCALE_W'(1);
        n_eff_d   = n_eff_q;
        pre_eff_d = pre_eff_q;
        mask_d    = mask_q;
        value_d   = value_q;
        wr_ptr_d  = wr_ptr_q;
        trig_d    = trig_q;
        post_d    = post_q;
        start_d   = start_q;
        rd_ofs_d  = rd_ofs_q;
        cnt_smp_d = cnt_smp_q;
        rd_d      = rd_q;
        err_d     = err_q;
        mem_we    = 1'b0;
        to_done   = 1'b0;
        rem       = n_eff_q - start_q;
        rd_idx    = '0;
        if (clear) begin
            state_d   = ST_IDLE;
            cnt_d     = '0;
            wr_ptr_d  = '0;
            trig_d    = '0;
            post_d    = '0;
            start_d   = '0;
            rd_ofs_d  = '0;
            cnt_smp_d = '0;
            rd_d      = '0;
            err_d     = '0;
        end else begin
            if (arm) begin
                if (busy) begin
                    err_d[ERR_ARM_BUSY] = 1'b1;
                end else if (!arm_go) begin
                    err_d[ERR_ARM_ZERO] = 1'b1;
                end else begin
                    n_eff_d   = n_arm;
                    pre_eff_d = pre_arm;
                    mask_d    = trig_mask;
                    value_d   = trig_value;
                    wr_ptr_d  = '0;
                    cnt_smp_d = '0;
                    cnt_d     = '0;
                    state_d   = (pre_arm != '0) ? ST_PRETRIG : ST_ARMED;
                end
            end
            if (busy && tick) begin
                mem_we   = 1'b1;
                wr_ptr_d = (wr_ptr_q == n_eff_q - CW'(1)) ? '0
                                                          : wr_ptr_q + CW'(1);
                if (cnt_smp_q != '1) cnt_smp_d = cnt_smp_q + 32'd1;
                unique case (state_q)
                    ST_PRETRIG: begin
                        if (cnt_smp_d >= 32'(pre_eff_q)) state_d = ST_ARMED;
                    end
                    ST_ARMED: begin
                        if (trig) begin
                            trig_d = wr_ptr_q;
                            post_d = post_val;
                            if (post_val == '0) to_done = 1'b1;
                            else state_d = ST_POSTTRIG;
                        end
                    end
                    ST_POSTTRIG: begin
                        post_d = post_q - CW'(1);
                        if (post_q == CW'(1)) to_done = 1'b1;
                    end
                    default: ;
                endcase
            end
            if (to_done) begin
                state_d  = ST_DONE;
                // True result lies in [0, n_eff), so wrap-around in CW bits is exact.
                start_d  = (trig_d >= pre_eff_q) ? trig_d - pre_eff_q
                                                 : trig_d + (n_eff_q - pre_eff_q);
                // Start slot may be the one being written this very cycle.
                rd_d     = (start_d == wr_ptr_q) ? input_signals
                                                 : mem_q[start_d[AW-1:0]];
                rd_ofs_d = CW'(1);
            end
            if (strb_rise) begin
                if (state_q != ST_DONE) begin
                    err_d[ERR_RD_IDLE] = 1'b1;
                end else if (rd_ofs_q == n_eff_q) begin
                    rd_d = '0;
                    err_d[ERR_RD_OVER] = 1'b1;
                end else begin
                    rd_idx   = (rd_ofs_q >= rem) ? AW'(rd_ofs_q - rem)
                                                 : AW'(start_q + rd_ofs_q);
                    rd_d     = mem_q[rd_idx];
                    rd_ofs_d = rd_ofs_q + CW'(1);
                end
            end
        end
    end

    always_ff @(posedge axi_clk or posedge axi_reset) begin
        if (axi_reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            n_eff_q   <= '0;
            pre_eff_q <= '0;
            mask_q    <= '0;
            value_q   <= '0;
            wr_ptr_q  <= '0;
            trig_q    <= '0;
            post_q    <= '0;
            start_q   <= '0;
            rd_ofs_q  <= '0;
            cnt_smp_q <= '0;
            rd_q      <= '0;
            err_q     <= '0;
            strb_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            n_eff_q   <= n_eff_d;
            pre_eff_q <= pre_eff_d;
            mask_q    <= mask_d;
            value_q   <= value_d;
            wr_ptr_q  <= wr_ptr_d;
            trig_q    <= trig_d;
            post_q    <= post_d;
            start_q   <= start_d;
            rd_ofs_q  <= rd_ofs_d;
            cnt_smp_q <= cnt_smp_d;
            rd_q      <= rd_d;
            err_q     <= err_d;
            strb_q    <= read_channel_rdStrobe;
        end
    end

    always_ff @(posedge axi_clk) begin
        if (mem_we) mem_q[wr_ptr_q[AW-1:0]] <= input_signals;
    end

    assign read_channel = rd_q;
    assign sample_count = cnt_smp_q;
    assign trig_index   = 32'(trig_q);
    assign status       = state_q;
    assign dbg_error    = 32'(err_q);

endmodule

// File: tb/tb_pattern_capture_analyzer.sv
// Self-checking bench for pattern_capture_analyzer: ramp-input capture table
// with a read-out scoreboard, plus hand sequences for timing/edge/clear/reset.
module tb_pattern_capture_analyzer;

    logic        axi_clk = 1'b0;
    logic        axi_reset;
    logic        arm, clear;
    logic [31:0] n_samples, pre_trigger;
    logic [15:0] prescale;
    logic [13:0] trig_mask, trig_value;
    logic [7:0]  control;
    logic [13:0] input_signals;
    logic        read_channel_rdStrobe;
    logic [13:0] read_channel;
    logic [31:0] sample_count, trig_index, dbg_error;
    logic [2:0]  status;

    int total = 0;
    int bad   = 0;
    logic [13:0] exp_q[$];

    typedef struct {
        int          n;
        int          pre;
        int          ps;
        logic [13:0] mask;
        logic [13:0] value;
        int          t;
        int          exp_trig;
        int          exp_cnt;
    } vec_t;

    vec_t vecs[5];

    pattern_capture_analyzer dut (
        .axi_clk               (axi_clk),
        .axi_reset             (axi_reset),
        .arm                   (arm),
        .clear                 (clear),
        .n_samples             (n_samples),
        .pre_trigger           (pre_trigger),
        .prescale              (prescale),
        .trig_mask             (trig_mask),
        .trig_value            (trig_value),
        .control               (control),
        .input_signals         (input_signals),
        .read_channel_rdStrobe (read_channel_rdStrobe),
        .read_channel          (read_channel),
        .sample_count          (sample_count),
        .trig_index            (trig_index),
        .status                (status),
        .dbg_error             (dbg_error)
    );

    always #5 axi_clk = ~axi_clk;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: sim time expired");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge axi_clk);
        #1;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        step();
        clear = 1'b0;
    endtask

    task automatic run_vec(input int i);
        vec_t v;
        int neff, peff, c, budget;
        bit done;
        logic [13:0] e;
        v = vecs[i];
        neff = (v.n > 128) ? 128 : v.n;
        peff = (v.pre > neff - 1) ? neff - 1 : v.pre;
        do_clear();
        n_samples   = v.n;
        pre_trigger = v.pre;
        prescale    = 16'(v.ps);
        trig_mask   = v.mask;
        trig_value  = v.value;
        control     = 8'h00;
        for (int k = 0; k < neff; k++) exp_q.push_back(14'(v.t - peff + k));
        arm = 1'b1;
        step();
        arm = 1'b0;
        c = 1;
        input_signals = 14'(c / (v.ps + 1) - 1);
        budget = (v.t + neff + 4) * (v.ps + 1) + 20;
        done = 1'b0;
        while (!done && c < budget) begin
            step();
            c++;
            input_signals = 14'(c / (v.ps + 1) - 1);
            if (status == 3'd4) done = 1'b1;
        end
        chk($sformatf("v%0d_done", i), 32'(done), 32'd1);
        chk($sformatf("v%0d_trig", i), trig_index, 32'(v.exp_trig));
        chk($sformatf("v%0d_cnt", i), sample_count, 32'(v.exp_cnt));
        for (int k = 0; k < neff; k++) begin
            e = exp_q.pop_front();
            chk($sformatf("v%0d_rd%0d", i, k), 32'(read_channel), 32'(e));
            // Strobe held two cycles must advance by one sample only.
            read_channel_rdStrobe = 1'b1;
            step();
            step();
            read_channel_rdStrobe = 1'b0;
            step();
        end
        chk($sformatf("v%0d_rd_over", i), 32'(read_channel), 32'd0);
        chk($sformatf("v%0d_err", i), dbg_error, 32'h2);
    endtask

    initial begin
        int first;
        vecs[0] = '{n: 8,   pre: 2,   ps: 0, mask: 14'h3FFF, value: 14'd5,
                    t: 5,   exp_trig: 5,  exp_cnt: 11};
        vecs[1] = '{n: 500, pre: 100, ps: 0, mask: 14'h3FFF, value: 14'd300,
                    t: 300, exp_trig: 44, exp_cnt: 328};
        vecs[2] = '{n: 4,   pre: 0,   ps: 3, mask: 14'h0000, value: 14'h1234,
                    t: 0,   exp_trig: 0,  exp_cnt: 4};
        vecs[3] = '{n: 16,  pre: 20,  ps: 1, mask: 14'h3FFF, value: 14'd40,
                    t: 40,  exp_trig: 8,  exp_cnt: 41};
        vecs[4] = '{n: 1,   pre: 0,   ps: 0, mask: 14'h3FFF, value: 14'd7,
                    t: 7,   exp_trig: 0,  exp_cnt: 8};

        axi_reset = 1'b1;
        arm = 1'b0;
        clear = 1'b0;
        n_samples = 0;
        pre_trigger = 0;
        prescale = 0;
        trig_mask = 0;
        trig_value = 0;
        control = 0;
        input_signals = 0;
        read_channel_rdStrobe = 1'b0;
        step();
        step();
        chk("rst_status", 32'(status), 32'd0);
        chk("rst_rd", 32'(read_channel), 32'd0);
        chk("rst_cnt", sample_count, 32'd0);
        chk("rst_trig", trig_index, 32'd0);
        chk("rst_err", dbg_error, 32'd0);
        axi_reset = 1'b0;
        step();
        chk("post_rst_status", 32'(status), 32'd0);

        for (int i = 0; i < 5; i++) run_vec(i);

        // Prescale timing: n=4, pre=0, prescale=3, mask=0.
        do_clear();
        n_samples = 4;
        pre_trigger = 0;
        prescale = 3;
        trig_mask = 0;
        arm = 1'b1;
        step();
        arm = 1'b0;
        first = 0;
        for (int c = 1; c <= 40 && first == 0; c++) begin
            step();
            if (status == 3'd4) first = c;
        end
        chk("ps_done_cycle", 32'(first), 32'd16);
        chk("ps_cnt", sample_count, 32'd4);

        // Edge mode: line already high at arm must not trigger.
        do_clear();
        n_samples = 8;
        pre_trigger = 0;
        prescale = 0;
        trig_mask = 14'h0001;
        trig_value = 14'h0001;
        control = 8'h01;
        input_signals = 14'h0001;
        arm = 1'b1;
        step();
        arm = 1'b0;
        for (int c = 1; c <= 5; c++) step();
        chk("edge_hold_status", 32'(status), 32'd2);
        input_signals = 14'h0000;
        step();
        chk("edge_low_status", 32'(status), 32'd2);
        input_signals = 14'h0001;
        step();
        chk("edge_rise_status", 32'(status), 32'd3);
        chk("edge_rise_trig", trig_index, 32'd6);
        control = 8'h00;

        // Clear during POSTTRIG.
        do_clear();
        chk("clr_status", 32'(status), 32'd0);
        chk("clr_cnt", sample_count, 32'd0);
        chk("clr_trig", trig_index, 32'd0);
        chk("clr_rd", 32'(read_channel), 32'd0);

        // arm and clear together: clear wins.
        arm = 1'b1;
        clear = 1'b1;
        step();
        arm = 1'b0;
        clear = 1'b0;
        step();
        chk("armclr_status", 32'(status), 32'd0);

        // Sticky error bits.
        read_channel_rdStrobe = 1'b1;
        step();
        read_channel_rdStrobe = 1'b0;
        step();
        chk("err_rd_idle", dbg_error, 32'h1);
        n_samples = 0;
        arm = 1'b1;
        step();
        arm = 1'b0;
        chk("err_arm_zero", dbg_error, 32'h5);
        chk("arm_zero_status", 32'(status), 32'd0);
        n_samples = 8;
        trig_mask = 14'h3FFF;
        trig_value = 14'h3FFF;
        input_signals = 14'h0000;
        arm = 1'b1;
        step();
        arm = 1'b0;
        chk("armed_status", 32'(status), 32'd2);
        arm = 1'b1;
        step();
        arm = 1'b0;
        chk("err_arm_busy", dbg_error, 32'hD);
        step();
        step();

        // Asynchronous reset mid-ARMED.
        axi_reset = 1'b1;
        #1;
        chk("arst_status", 32'(status), 32'd0);
        chk("arst_cnt", sample_count, 32'd0);
        chk("arst_err", dbg_error, 32'd0);
        #2;
        axi_reset = 1'b0;
        step();
        run_vec(0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
